// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator, one byte per valid/ready handshake.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } state_t;

  localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_END  = 16'(CS_IDLE - 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction
  function automatic logic [7:0] rx_shift(input logic [7:0] b,
                                          input logic s);
    return {s, b[7:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] rx_shift(input logic [7:0] b,
                                          input logic s);
    return {b[6:0], s};
  endfunction
`endif

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [7:0]  rx_data_n;
  logic        last_q, last_n;
  logic        rx_valid_n;
  logic        sck_n, cs_n, mosi_n;
  logic        half_end, byte_end, accept;

  assign half_end = (cnt == DIV_END);
  assign byte_end = (state == SHIFT) && half_end
                 && spi_sck && (bit_cnt == 3'd7);

  // The final high cycle of a non-last byte doubles as NEXT,
  // so a held tx_valid keeps the SCK cadence unbroken.
  assign tx_ready = (state == IDLE) || (state == NEXT)
                 || (byte_end && !last_q);
  assign accept   = tx_ready && tx_valid;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    tx_sh_n    = tx_sh;
    rx_sh_n    = rx_sh;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    last_n     = last_q;
    sck_n      = spi_sck;
    cs_n       = spi_cs;
    mosi_n     = spi_mosi;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cs_n    = 1'b0;
          cnt_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_END) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          mosi_n    = first_bit(tx_sh);
          state_n   = SHIFT;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      SHIFT: begin
        if (!half_end) begin
          cnt_n = cnt + 16'd1;
        end else begin
          cnt_n = '0;
          sck_n = !spi_sck;
          if (!spi_sck) begin
            rx_sh_n = rx_shift(rx_sh, spi_miso);
          end else if (bit_cnt != 3'd7) begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_sh_n   = tx_shift(tx_sh);
            mosi_n    = first_bit(tx_shift(tx_sh));
          end else begin
            rx_valid_n = 1'b1;
            rx_data_n  = rx_sh;
            state_n    = last_q ? HOLD : NEXT;
          end
        end
      end
      NEXT: begin
        sck_n = 1'b0;
      end
      HOLD: begin
        if (cnt == HOLD_END) begin
          cs_n    = 1'b1;
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      GAP: begin
        if (cnt == IDLE_END) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (accept) begin
      tx_sh_n = tx_data;
      last_n  = tx_last;
      if (state != IDLE) begin
        state_n   = SHIFT;
        cnt_n     = '0;
        bit_cnt_n = '0;
        mosi_n    = first_bit(tx_data);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      last_q   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_sck  <= 1'b0;
      spi_cs   <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_sh    <= tx_sh_n;
      rx_sh    <= rx_sh_n;
      last_q   <= last_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      spi_sck  <= sck_n;
      spi_cs   <= cs_n;
      spi_mosi <= mosi_n;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: bench for spi_master with a mode-0 slave model.
// Instance a runs CLK_DIV=4, instance b runs CLK_DIV=1.
module tb_spi_master;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_tx_data = '0, a_rx_data;
  logic a_tx_valid = 0, a_tx_last = 0, a_tx_ready;
  logic a_rx_valid, a_busy, a_sck, a_cs, a_mosi;
  logic a_miso = 0;

  logic [7:0] b_tx_data = '0, b_rx_data;
  logic b_tx_valid = 0, b_tx_last = 0, b_tx_ready;
  logic b_rx_valid, b_busy, b_sck, b_cs, b_mosi;
  logic b_miso = 0;

  spi_master #(.CLK_DIV(4), .CS_SETUP(CS_SETUP),
               .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut_a (
    .clk(clk), .rst(rst),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_last(a_tx_last), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .busy(a_busy), .spi_sck(a_sck), .spi_cs(a_cs),
    .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  spi_master #(.CLK_DIV(1), .CS_SETUP(CS_SETUP),
               .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut_b (
    .clk(clk), .rst(rst),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_last(b_tx_last), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .busy(b_busy), .spi_sck(b_sck), .spi_cs(b_cs),
    .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_low = 0;
  logic [7:0] slave_q[$], mosi_q[$], rx_q[$];
  logic [7:0] exp_tx[$], exp_rx[$];
  logic mosi_bits[$];
  int rise_q[$];

  int cyc_b = 0, b_low = 0, b_hi = 0, b_acc = 0;
  int b_rise[$], b_hi_q[$];
  logic [7:0] b_rx[$];

  function automatic int bpos(input int k);
    return LSB ? k : 7 - k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode-0 slave: shifts out on SCK fall, captures MOSI on SCK rise
  initial begin : mon_a
    logic pa_sck, pa_cs;
    logic [7:0] cur, mb;
    int sk, nr;
    pa_sck = 0; pa_cs = 1; cur = 0; mb = 0; sk = 0; nr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sk = 0; nr = 0; a_miso = 1'b0;
      end else begin
        if (pa_cs && !a_cs) begin
          sk = 0; nr = 0;
          cur = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
          a_miso = cur[bpos(0)];
        end
        if (!a_cs && !pa_sck && a_sck) begin
          rise_q.push_back(cyc);
          mosi_bits.push_back(a_mosi);
          mb[bpos(nr)] = a_mosi;
          nr++;
          if (nr == 8) begin
            mosi_q.push_back(mb);
            nr = 0;
          end
        end
        if (!a_cs && pa_sck && !a_sck) begin
          sk++;
          if (sk == 8) begin
            sk = 0;
            if (slave_q.size() > 0) cur = slave_q.pop_front();
          end
          a_miso = cur[bpos(sk)];
        end
        if (!a_cs) cs_low++;
        if (a_rx_valid) rx_q.push_back(a_rx_data);
      end
      pa_sck = a_sck;
      pa_cs = a_cs;
    end
  end

  initial begin : mon_b
    logic pb_sck, pb_cs;
    pb_sck = 0; pb_cs = 1;
    forever begin
      @(negedge clk);
      cyc_b++;
      if (!rst) begin
        if (!b_cs) b_low++;
        if (b_cs) b_hi++;
        if (pb_cs && !b_cs) begin
          b_hi_q.push_back(b_hi);
          b_hi = 0;
        end
        if (!b_cs && !pb_sck && b_sck) b_rise.push_back(cyc_b);
        if (b_tx_valid && b_tx_ready) b_acc++;
        if (b_rx_valid) b_rx.push_back(b_rx_data);
      end
      pb_sck = b_sck;
      pb_cs = b_cs;
    end
  end

  task automatic start_test();
    slave_q.delete(); mosi_q.delete(); rx_q.delete();
    rise_q.delete(); mosi_bits.delete();
    exp_tx.delete(); exp_rx.delete();
    cs_low = 0;
  endtask

  task automatic add(input logic [7:0] t, input logic [7:0] s);
    exp_tx.push_back(t);
    exp_rx.push_back(s);
    slave_q.push_back(s);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    if (!a_tx_valid) begin
      @(posedge clk); #1;
    end
    a_tx_data = d; a_tx_valid = 1'b1; a_tx_last = l;
    @(negedge clk);
    while (!a_tx_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 4000), 1);
    @(posedge clk); #1;
    if (l) begin
      a_tx_valid = 1'b0; a_tx_last = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (a_busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(n < 4000), 1);
  endtask

  task automatic burst();
    for (int i = 0; i < exp_tx.size(); i++)
      send(exp_tx[i], i == exp_tx.size() - 1);
    wait_idle();
  endtask

  task automatic chk_burst(input string tag);
    chk({tag, "_ntx"}, mosi_q.size(), exp_tx.size());
    chk({tag, "_nrx"}, rx_q.size(), exp_rx.size());
    chk({tag, "_nsck"}, rise_q.size(), 8 * exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      chk({tag, "_mosi"},
          i < mosi_q.size() ? 32'(mosi_q[i]) : 32'hdead, exp_tx[i]);
      chk({tag, "_miso"},
          i < rx_q.size() ? 32'(rx_q[i]) : 32'hdead, exp_rx[i]);
    end
  endtask

  task automatic chk_cadence(input string tag, input int per);
    int bad;
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != per) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, len, gap_bad, bad;
    logic m;

    repeat (3) @(negedge clk);
    chk("rst_cs", a_cs, 1);
    chk("rst_sck", a_sck, 0);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_rx_data", a_rx_data, 0);
    chk("rst_rx_valid", a_rx_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_tx_ready", a_tx_ready, 1);
    #2 rst = 1'b0;

    start_test();
    add(8'hA5, 8'h3C);
    burst();
    chk_burst("t1");
    chk("t1_rx_data", a_rx_data, 8'h3C);
    chk("t1_cs_low", cs_low, CS_SETUP + 64 + CS_HOLD);
    chk_cadence("t1_period", 8);

    start_test();
    add(8'h01, 8'h80);
    burst();
    chk_burst("t6");
    chk("t6_first_bit", mosi_bits.size() > 0 ? mosi_bits[0] : 1'bx,
        LSB ? 1 : 0);
    chk("t6_last_bit", mosi_bits.size() > 7 ? mosi_bits[7] : 1'bx,
        LSB ? 0 : 1);

    start_test();
    add(8'h01, 8'($urandom));
    add(8'h02, 8'($urandom));
    add(8'h03, 8'($urandom));
    burst();
    chk_burst("t2");
    chk("t2_cs_low", cs_low, CS_SETUP + 3 * 64 + CS_HOLD);
    chk_cadence("t2_period", 8);

    start_test();
    add(8'h55, 8'($urandom));
    add(8'hAA, 8'($urandom));
    send(8'h55, 1'b0);
    a_tx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a_rx_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t3_rx_wait", 32'(n < 1000), 1);
    gap_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (a_sck !== 1'b0 || a_cs !== 1'b0 || a_tx_ready !== 1'b1
          || a_rx_data !== exp_rx[0])
        gap_bad++;
    end
    chk("t3_gap", gap_bad, 0);
    send(8'hAA, 1'b1);
    wait_idle();
    chk_burst("t3");

    for (int r = 0; r < 3; r++) begin
      start_test();
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) add(8'($urandom), 8'($urandom));
      burst();
      chk_burst("rnd");
      chk("rnd_cs_low", cs_low, CS_SETUP + 64 * len + CS_HOLD);
      chk_cadence("rnd_period", 8);
    end

    start_test();
    add(8'h96, 8'h69);
    send(8'h96, 1'b1);
    n = 0;
    while (rise_q.size() < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_cs_async", a_cs, 1);
    chk("t4_sck_async", a_sck, 0);
    chk("t4_mosi_async", a_mosi, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t4_tx_ready", a_tx_ready, 1);
    chk("t4_no_rx_valid", rx_q.size(), 0);
    start_test();
    add(8'h5A, 8'hC3);
    burst();
    chk_burst("t4_after");

    m = 1'($urandom_range(0, 1));
    b_miso = m;
    b_low = 0; b_acc = 0;
    b_rise.delete(); b_hi_q.delete(); b_rx.delete();
    @(posedge clk); #1;
    b_tx_data = 8'hFF; b_tx_last = 1'b1; b_tx_valid = 1'b1;
    n = 0;
    while (b_acc < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_accepts", b_acc, 2);
    @(posedge clk); #1;
    b_tx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (b_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_idle", 32'(n < 2000), 1);
    chk("t5_nsck", b_rise.size(), 16);
    bad = 0;
    for (int i = 1; i < b_rise.size(); i++)
      if (i % 8 != 0 && b_rise[i] - b_rise[i-1] != 2) bad++;
    chk("t5_period", bad, 0);
    chk("t5_cs_low", b_low, 2 * (CS_SETUP + 16 + CS_HOLD));
    chk("t5_cs_idle",
        b_hi_q.size() > 1 ? 32'(b_hi_q[1] >= CS_IDLE) : 32'hdead, 1);
    chk("t5_nrx", b_rx.size(), 2);
    for (int i = 0; i < b_rx.size(); i++)
      chk("t5_rx", b_rx[i], {8{m}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
